// File: rtl/instr_stream_loader_pkg.sv
// Shared definitions for the instruction stream loader: FSM encoding and frame constants.
package instr_stream_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_HI  = 3'd1,
    HDR_LO  = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4,
    RUN     = 3'd5,
    ERROR   = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

endpackage

// File: rtl/instr_word_assembler.sv
// Packs a big-endian byte stream into words; flags the byte that completes a word.
module instr_word_assembler
  import instr_stream_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word_next,
  output logic              word_complete
);

  // Only the bytes already received are stored; the incoming byte completes the word.
  logic [DATA_W-9:0] shreg;
  logic [1:0]        byte_cnt;

  assign word_next     = {shreg, byte_in};
  assign word_complete = byte_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (byte_en) begin
      shreg    <= word_next[DATA_W-9:0];
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_stream_loader.sv
// Loads a checksummed byte-stream program image into instruction memory,
// holding the core in reset until the image verifies.
module instr_stream_loader
  import instr_stream_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              instr_WE,
  output logic [ADDR_W-1:0] instr_WA,
  output logic [DATA_W-1:0] instr_WD,
  output logic              core_rstn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Handshake: a byte moves on a rising clk edge where s_valid && s_ready;
  // s_ready depends only on state, never on s_valid.
  state_t              state, state_next;
  logic [7:0]          n_hi;
  logic [15:0]         n_words;
  logic [15:0]         hdr_n;
  logic [ADDR_W-1:0]   word_idx;
  logic [CSUM_W-1:0]   csum;
  logic                xfer;
  logic                start_ok;
  logic                last_word;
  logic                word_complete;
  logic [DATA_W-1:0]   word_next;

  assign s_ready   = (state == HDR_HI) || (state == HDR_LO) ||
                     (state == PAYLOAD) || (state == CHECK);
  assign busy      = s_ready;
  assign done      = (state == RUN);
  assign core_rstn = (state == RUN);
  assign err       = (state == ERROR);

  assign xfer      = s_valid && s_ready;
  assign start_ok  = start && ((state == IDLE) || (state == RUN) || (state == ERROR));
  assign hdr_n     = {n_hi, s_data};
  assign last_word = (16'(word_idx) == (n_words - 16'd1));

  instr_word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk           (clk),
    .rstn          (rstn),
    .clr           (start_ok),
    .byte_en       (xfer && (state == PAYLOAD)),
    .byte_in       (s_data),
    .word_next     (word_next),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, RUN, ERROR: if (start) state_next = HDR_HI;
      HDR_HI:           if (s_valid) state_next = HDR_LO;
      HDR_LO: begin
        if (s_valid) begin
          if ((hdr_n == 16'd0) || (hdr_n > 16'(DEPTH))) state_next = ERROR;
          else                                          state_next = PAYLOAD;
        end
      end
      PAYLOAD:          if (word_complete && last_word) state_next = CHECK;
      CHECK: begin
        if (s_valid) state_next = (s_data == csum) ? RUN : ERROR;
      end
      default:          state_next = IDLE;
    endcase
  end

  // Write port registers: the word write lands the cycle after its last byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_hi     <= '0;
      n_words  <= '0;
      word_idx <= '0;
      csum     <= '0;
      instr_WE <= 1'b0;
      instr_WA <= '0;
      instr_WD <= '0;
    end else begin
      instr_WE <= 1'b0;
      if (start_ok) begin
        n_hi     <= '0;
        n_words  <= '0;
        word_idx <= '0;
        csum     <= '0;
      end else if (xfer) begin
        case (state)
          HDR_HI: n_hi    <= s_data;
          HDR_LO: n_words <= hdr_n;
          PAYLOAD: begin
            csum <= csum + s_data;
            if (word_complete) begin
              instr_WE <= 1'b1;
              instr_WA <= word_idx;
              instr_WD <= word_next;
              word_idx <= word_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_stream_loader.sv
// Randomized scoreboard bench for instr_stream_loader: a frame-level model
// predicts memory writes and the final load outcome.
module tb_instr_stream_loader;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready;
  logic              instr_WE;
  logic [ADDR_W-1:0] instr_WA;
  logic [DATA_W-1:0] instr_WD;
  logic              core_rstn;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;
  int gap_mode = 0;  // 0: back-to-back, 1: random gaps, 2: valid every other cycle

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [7:0]               frame_q[$];
  logic [31:0]              words[$];
  bit                       ok;

  instr_stream_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .instr_WE  (instr_WE),
    .instr_WA  (instr_WA),
    .instr_WD  (instr_WD),
    .core_rstn (core_rstn),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write pulse is matched against the next expected write.
  always @(negedge clk) begin
    if (rstn && instr_WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got WA=%0h WD=%0h expected no write", instr_WA, instr_WD);
      end else begin
        check("write", {instr_WA, instr_WD}, exp_q.pop_front());
      end
    end
  end

  // Reference model: builds the frame and predicts writes and outcome.
  task automatic build_load(input int n, input logic [7:0] corrupt, output bit load_ok);
    logic [7:0] sum;
    logic [31:0] w;
    frame_q.delete();
    frame_q.push_back(8'((n >> 8) & 255));
    frame_q.push_back(8'(n & 255));
    load_ok = 1'b0;
    if (n >= 1 && n <= DEPTH) begin
      sum = 8'h00;
      for (int k = 0; k < n; k++) begin
        w = words[k];
        for (int b = 3; b >= 0; b--) begin
          frame_q.push_back(8'((w >> (8 * b)) & 32'hFF));
          sum = sum + 8'((w >> (8 * b)) & 32'hFF);
        end
        exp_q.push_back({ADDR_W'(k), w});
      end
      frame_q.push_back(sum + corrupt);
      load_ok = (corrupt == 8'h00);
    end
  endtask

  // Drivers
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      int gap;
      int budget;
      bit sent;
      gap = (gap_mode == 1) ? int'($urandom_range(0, 2)) : ((gap_mode == 2) ? 1 : 0);
      repeat (gap) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = frame_q[i];
      sent    = 1'b0;
      budget  = 0;
      while (!sent) begin
        @(negedge clk);
        sent = s_ready;
        @(posedge clk); #1;
        budget++;
        if (!sent && budget > 50) begin
          checks++;
          errors++;
          $display("FAIL byte_accept_timeout: got s_ready=0 expected 1 at byte %0d", i);
          s_valid = 1'b0;
          return;
        end
      end
      s_valid = 1'b0;
    end
  endtask

  task automatic check_status(input string tag, input bit load_ok);
    @(negedge clk);
    check({tag, "_done"},      done,      load_ok);
    check({tag, "_core_rstn"}, core_rstn, load_ok);
    check({tag, "_err"},       err,       !load_ok);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_s_ready"},   s_ready,   1'b0);
    check({tag, "_pending"},   exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"},   s_ready,   1'b0);
    check({tag, "_we"},        instr_WE,  1'b0);
    check({tag, "_wa"},        instr_WA,  '0);
    check({tag, "_wd"},        instr_WD,  '0);
    check({tag, "_core_rstn"}, core_rstn, 1'b0);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_done"},      done,      1'b0);
    check({tag, "_err"},       err,       1'b0);
  endtask

  task automatic set_frame1();
    words.delete();
    words.push_back(32'h20080005);
    words.push_back(32'h2009000A);
  endtask

  task automatic random_words(input int n);
    words.delete();
    for (int k = 0; k < n; k++) words.push_back($urandom);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Basic load, then the same frame with a bad checksum.
    set_frame1();
    build_load(2, 8'h00, ok);
    check("frame1_csum_byte", frame_q[10], 8'h60);
    pulse_start();
    send_range(0, frame_q.size());
    check_status("basic", ok);

    build_load(2, 8'h01, ok);
    pulse_start();
    send_range(0, frame_q.size());
    check_status("bad_csum", ok);

    // Header errors: zero words and more than DEPTH words.
    words.delete();
    build_load(0, 8'h00, ok);
    pulse_start();
    send_range(0, frame_q.size());
    check_status("hdr_zero", ok);
    build_load(16'h0101, 8'h00, ok);
    pulse_start();
    send_range(0, frame_q.size());
    check_status("hdr_big", ok);

    // Full depth with valid toggling every other cycle.
    words.delete();
    for (int k = 0; k < DEPTH; k++) words.push_back(32'h00010000 + k);
    gap_mode = 2;
    build_load(DEPTH, 8'h00, ok);
    pulse_start();
    send_range(0, frame_q.size());
    check("last_wa", instr_WA, 8'hFF);
    check_status("full_depth", ok);
    gap_mode = 0;

    // Reset after five payload bytes, then replay frame 1.
    set_frame1();
    build_load(2, 8'h00, ok);
    void'(exp_q.pop_back());
    pulse_start();
    send_range(0, 7);
    rstn = 1'b0;
    #1;
    check_reset_values("mid_reset_async");
    @(negedge clk);
    check_reset_values("mid_reset_held");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    build_load(2, 8'h00, ok);
    pulse_start();
    send_range(0, frame_q.size());
    check_status("after_reset", ok);

    // Start during PAYLOAD is ignored.
    random_words(3);
    build_load(3, 8'h00, ok);
    pulse_start();
    send_range(0, 5);
    pulse_start();
    send_range(5, frame_q.size());
    check_status("start_in_payload", ok);

    // Start in RUN restarts a load.
    pulse_start();
    @(negedge clk);
    check("restart_core_rstn", core_rstn, 1'b0);
    check("restart_done",      done,      1'b0);
    check("restart_busy",      busy,      1'b1);
    check("restart_s_ready",   s_ready,   1'b1);
    @(posedge clk); #1;
    random_words(2);
    build_load(2, 8'h00, ok);
    send_range(0, frame_q.size());
    check_status("restart_load", ok);

    // Randomized loads with random gaps and occasional checksum corruption.
    gap_mode = 1;
    for (int t = 0; t < 8; t++) begin
      int n;
      logic [7:0] corrupt;
      n = int'($urandom_range(1, 9));
      corrupt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      random_words(n);
      build_load(n, corrupt, ok);
      pulse_start();
      send_range(0, frame_q.size());
      check_status("random", ok);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
